// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared command codes, size defaults and FSM encoding for the lcd host driver
//
// Contents:
//   CMD_* : command codes understood by lcd_ctrl
//   *_DEF : default sizes (pixel width, image/window pixel counts, timeout)
//   state_t : host driver FSM states
//   cmd_is_legal() : true for the six codes lcd_ctrl implements

package lcd_pkg;

    localparam int DW_DEF      = 8;
    localparam int IMG_PIX_DEF = 36;
    localparam int WIN_PIX_DEF = 9;
    localparam int TIMEOUT_DEF = 64;

    localparam logic [2:0] CMD_OUT   = 3'd0;
    localparam logic [2:0] CMD_LOAD  = 3'd1;
    localparam logic [2:0] CMD_RIGHT = 3'd2;
    localparam logic [2:0] CMD_LEFT  = 3'd3;
    localparam logic [2:0] CMD_UP    = 3'd4;
    localparam logic [2:0] CMD_DOWN  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_LOAD,
        ST_COLLECT
    } state_t;

    // Codes 6 and 7 have no meaning to lcd_ctrl and are rejected before issue.
    function automatic logic cmd_is_legal(input logic [2:0] code);
        return (code <= CMD_DOWN);
    endfunction

endpackage

// File: rtl/lcd_win_capture.sv
// rtl/lcd_win_capture.sv - collects one output burst into a shadow window, commits it on success
//
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clear      : start of a new command; rewinds the pixel index and overflow flag
//   capture    : a returned pixel is present on pixel this cycle
//   pixel      : returned pixel value
//   commit     : copy the shadow window to win_data
//   full       : exactly WIN_PIX pixels captured and no surplus seen
//   win_data   : last successfully committed window, pixel n at [DW*n +: DW]

module lcd_win_capture
    import lcd_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int WIN_PIX = WIN_PIX_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  capture,
    input  logic [DW-1:0]         pixel,
    input  logic                  commit,
    output logic                  full,
    output logic [DW*WIN_PIX-1:0] win_data
);

    localparam int IW = $clog2(WIN_PIX + 1);

    logic [IW-1:0]         idx;
    logic                  ovf;
    logic [DW*WIN_PIX-1:0] shadow;

    // The shadow keeps a failed burst away from win_data, so a short or long
    // burst leaves the previously delivered window visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx      <= '0;
            ovf      <= 1'b0;
            shadow   <= '0;
            win_data <= '0;
        end else begin
            if (clear) begin
                idx <= '0;
                ovf <= 1'b0;
            end else if (capture) begin
                if (idx == IW'(WIN_PIX)) begin
                    ovf <= 1'b1;
                end else begin
                    idx <= idx + 1'b1;
                    for (int n = 0; n < WIN_PIX; n++) begin
                        if (idx == IW'(n)) begin
                            shadow[n*DW +: DW] <= pixel;
                        end
                    end
                end
            end
            if (commit) begin
                win_data <= shadow;
            end
        end
    end

    assign full = (idx == IW'(WIN_PIX)) && !ovf;

endmodule

// File: rtl/lcd_host_driver.sv
// rtl/lcd_host_driver.sv - single-outstanding command initiator for lcd_ctrl with image streaming and window capture
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   req_cmd/req_valid   : command request from the sequencer
//   req_ready           : high while idle
//   img_addr/img_data   : image RAM read port, one cycle read latency
//   cmd/cmd_valid       : command issue to lcd_ctrl
//   datain              : image pixel to lcd_ctrl during LOAD, otherwise 0
//   dataout/output_valid: returned window pixels from lcd_ctrl
//   busy                : lcd_ctrl busy
//   win_data/win_valid  : packed returned window, pulse on each good burst
//   err                 : one-cycle pulse on illegal code, bad burst length or timeout

module lcd_host_driver
    import lcd_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int IMG_PIX = IMG_PIX_DEF,
    parameter int WIN_PIX = WIN_PIX_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            req_cmd,
    input  logic                  req_valid,
    output logic                  req_ready,
    output logic [5:0]            img_addr,
    input  logic [DW-1:0]         img_data,
    output logic [2:0]            cmd,
    output logic                  cmd_valid,
    output logic [DW-1:0]         datain,
    input  logic [DW-1:0]         dataout,
    input  logic                  output_valid,
    input  logic                  busy,
    output logic [DW*WIN_PIX-1:0] win_data,
    output logic                  win_valid,
    output logic                  err
);

    localparam int         TW       = $clog2(TIMEOUT + 1);
    localparam logic [5:0] LAST_PIX = 6'(IMG_PIX - 1);

    state_t         state, state_n;
    logic [2:0]     cmd_q;
    logic [5:0]     k;
    logic [TW-1:0]  tcnt;
    logic           err_n;
    logic           win_valid_n;
    logic           clear;
    logic           commit;
    logic           full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cmd_q     <= '0;
            k         <= '0;
            tcnt      <= '0;
            err       <= 1'b0;
            win_valid <= 1'b0;
        end else begin
            state     <= state_n;
            err       <= err_n;
            win_valid <= win_valid_n;
            if (state == ST_IDLE && req_valid) begin
                cmd_q <= req_cmd;
            end
            // k counts cycles since the LOAD handshake; it only advances while
            // staying in LOAD so it never exceeds LAST_PIX.
            if (state == ST_LOAD && state_n == ST_LOAD) begin
                k <= k + 6'd1;
            end else begin
                k <= '0;
            end
            // Timeout counter restarts on every state change and saturates.
            if (state_n != state) begin
                tcnt <= '0;
            end else if (tcnt != TW'(TIMEOUT)) begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_n     = state;
        err_n       = 1'b0;
        win_valid_n = 1'b0;
        clear       = 1'b0;
        commit      = 1'b0;
        req_ready   = 1'b0;
        cmd_valid   = 1'b0;
        cmd         = '0;
        datain      = '0;
        img_addr    = '0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    clear = 1'b1;
                    if (cmd_is_legal(req_cmd)) begin
                        state_n = ST_ISSUE;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                // img_addr stays 0 here so pixel 0 is on img_data in the first LOAD cycle.
                cmd_valid = 1'b1;
                cmd       = cmd_q;
                if (!busy) begin
                    state_n = (cmd_q == CMD_LOAD) ? ST_LOAD : ST_COLLECT;
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    err_n   = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_LOAD: begin
                datain   = img_data;
                img_addr = (k == LAST_PIX) ? LAST_PIX : k + 6'd1;
                if (k == LAST_PIX) begin
                    state_n = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                // busy is still high from the handshake in the first cycle, so
                // its level there says nothing about completion.
                if (tcnt != '0 && !busy) begin
                    state_n = ST_IDLE;
                    if (full) begin
                        win_valid_n = 1'b1;
                        commit      = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    err_n   = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    lcd_win_capture #(
        .DW      (DW),
        .WIN_PIX (WIN_PIX)
    ) u_capture (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .capture  ((state == ST_COLLECT) && output_valid),
        .pixel    (dataout),
        .commit   (commit),
        .full     (full),
        .win_data (win_data)
    );

endmodule
